// File: rtl/dac_driver_pkg.sv
// rtl/dac_driver_pkg.sv - shared types and constants for the serial DAC driver
package dac_driver_pkg;
  localparam int DAC_DATA_W = 16;
  localparam logic [3:0] BIT_LAST = 4'd15;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    SHIFT,
    GAP
  } state_t;
endpackage

// File: rtl/dac_clk_div.sv
// rtl/dac_clk_div.sv - half-period tick generator, one tick every CLK_DIV clk cycles
module dac_clk_div #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);
  logic [7:0] cnt;

  assign tick = (cnt == 8'(CLK_DIV - 1));

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt <= 8'd0;
    end else if (tick) begin
      cnt <= 8'd0;
    end else begin
      cnt <= cnt + 8'd1;
    end
  end
endmodule

// File: rtl/dac_driver.sv
// rtl/dac_driver.sv - 16-bit SPI-style DAC frame driver; DAC_DRIVER_LDAC_EN adds an LDAC pulse output
module dac_driver
  import dac_driver_pkg::*;
#(
  parameter int CLK_DIV    = 2,
  parameter int GAP_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DAC_DATA_W-1:0] din,
  input  logic                  din_valid,
  output logic                  din_ready,
  output logic                  CS,
  output logic                  SCLK,
  output logic                  SDI,
  output logic                  busy
`ifdef DAC_DRIVER_LDAC_EN
  ,
  output logic                  LDAC
`endif
);
  state_t                state, state_n;
  logic [DAC_DATA_W-1:0] shreg, shreg_n;
  logic [3:0]            bit_cnt, bit_cnt_n;
  logic [7:0]            gap_cnt, gap_cnt_n;
  logic                  cs_nx, sclk_nx;
  logic                  start, tick;

  dac_clk_div #(.CLK_DIV(CLK_DIV)) u_clk_div (
    .clk   (clk),
    .rst   (rst),
    .clear (start),
    .tick  (tick)
  );

  // SDI is the shift register MSB, so it moves only on load (CS fall) or on a rising SCLK
  assign SDI = shreg[DAC_DATA_W-1];

  always_comb begin
    state_n   = state;
    shreg_n   = shreg;
    bit_cnt_n = bit_cnt;
    gap_cnt_n = gap_cnt;
    cs_nx     = CS;
    sclk_nx   = SCLK;
    start     = 1'b0;
    case (state)
      IDLE: begin
        if (din_valid && din_ready) begin
          start     = 1'b1;
          state_n   = SETUP;
          shreg_n   = din;
          bit_cnt_n = 4'd0;
          cs_nx     = 1'b0;
        end
      end
      SETUP: begin
        if (tick) begin
          sclk_nx = 1'b0;
          state_n = SHIFT;
        end
      end
      SHIFT: begin
        if (tick) begin
          if (SCLK) begin
            sclk_nx = 1'b0;
          end else if (bit_cnt == BIT_LAST) begin
            sclk_nx   = 1'b1;
            cs_nx     = 1'b1;
            gap_cnt_n = 8'd0;
            state_n   = GAP;
          end else begin
            sclk_nx   = 1'b1;
            bit_cnt_n = bit_cnt + 4'd1;
            shreg_n   = {shreg[DAC_DATA_W-2:0], 1'b0};
          end
        end
      end
      GAP: begin
        if (gap_cnt == 8'(GAP_CYCLES - 1)) begin
          state_n = IDLE;
        end else begin
          gap_cnt_n = gap_cnt + 8'd1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      shreg     <= '0;
      bit_cnt   <= 4'd0;
      gap_cnt   <= 8'd0;
      CS        <= 1'b1;
      SCLK      <= 1'b1;
      busy      <= 1'b0;
      din_ready <= 1'b0;
    end else begin
      state     <= state_n;
      shreg     <= shreg_n;
      bit_cnt   <= bit_cnt_n;
      gap_cnt   <= gap_cnt_n;
      CS        <= cs_nx;
      SCLK      <= sclk_nx;
      busy      <= (state_n != IDLE);
      din_ready <= (state_n == IDLE);
    end
  end

`ifdef DAC_DRIVER_LDAC_EN
  // the LDAC pulse must finish inside the gap
  if (GAP_CYCLES < CLK_DIV + 1) begin : g_ldac_chk
    $error("dac_driver: GAP_CYCLES must be >= CLK_DIV+1 when LDAC is enabled");
  end

  // gap_cnt 0 is the CS-rise cycle; LDAC is low for gap counts 1..CLK_DIV
  always_ff @(posedge clk) begin
    if (rst) begin
      LDAC <= 1'b1;
    end else begin
      LDAC <= !((state_n == GAP) && (gap_cnt_n >= 8'd1) && (gap_cnt_n <= 8'(CLK_DIV)));
    end
  end
`endif
endmodule

// File: tb/tb_dac_driver.sv
// tb/tb_dac_driver.sv - directed self-checking bench for dac_driver
module tb_dac_driver;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] din0 = 16'h0, din1 = 16'h0;
  logic        dv0 = 1'b0, dv1 = 1'b0;
  logic        rdy0, rdy1, cs0, cs1, sclk0, sclk1, sdi0, sdi1, busy0, busy1;
  logic [1:0]  rdy, cs_w, sclk_w, sdi_w;
  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign rdy    = {rdy1, rdy0};
  assign cs_w   = {cs1, cs0};
  assign sclk_w = {sclk1, sclk0};
  assign sdi_w  = {sdi1, sdi0};

`ifdef DAC_DRIVER_LDAC_EN
  logic ldac0, ldac1;
`endif

  dac_driver #(.CLK_DIV(2), .GAP_CYCLES(4)) u_dut0 (
    .clk(clk), .rst(rst), .din(din0), .din_valid(dv0), .din_ready(rdy0),
    .CS(cs0), .SCLK(sclk0), .SDI(sdi0), .busy(busy0)
`ifdef DAC_DRIVER_LDAC_EN
    , .LDAC(ldac0)
`endif
  );

  dac_driver #(.CLK_DIV(1), .GAP_CYCLES(4)) u_dut1 (
    .clk(clk), .rst(rst), .din(din1), .din_valid(dv1), .din_ready(rdy1),
    .CS(cs1), .SCLK(sclk1), .SDI(sdi1), .busy(busy1)
`ifdef DAC_DRIVER_LDAC_EN
    , .LDAC(ldac1)
`endif
  );

  // DAC model: samples SDI on falling SCLK while CS is low, latches the word on CS rise
  logic [1:0]  p_cs, p_sclk, p_sdi;
  logic [15:0] shf [2];
  logic [15:0] word [2];
  int falls [2] = '{0, 0};
  int frames [2] = '{0, 0};
  int viol [2] = '{0, 0};
  int cs_fall_c [2] = '{0, 0};
  int cs_rise_c [2] = '{0, 0};
  int first_fall_c [2] = '{0, 0};
  int last_fall_c [2] = '{0, 0};
  int gap_meas [2] = '{0, 0};

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      p_cs[i]   <= cs_w[i];
      p_sclk[i] <= sclk_w[i];
      p_sdi[i]  <= sdi_w[i];
      if (p_cs[i] === 1'b1 && cs_w[i] === 1'b0) begin
        cs_fall_c[i] <= cyc;
        gap_meas[i]  <= cyc - cs_rise_c[i];
        falls[i]     <= 0;
      end else if (p_sclk[i] === 1'b1 && sclk_w[i] === 1'b0 && cs_w[i] === 1'b0) begin
        shf[i]         <= {shf[i][14:0], sdi_w[i]};
        falls[i]       <= falls[i] + 1;
        last_fall_c[i] <= cyc;
        if (falls[i] == 0) first_fall_c[i] <= cyc;
      end
      if (p_cs[i] === 1'b0 && cs_w[i] === 1'b1) begin
        cs_rise_c[i] <= cyc;
        word[i]      <= shf[i];
        frames[i]    <= frames[i] + 1;
      end
      if (sclk_w[i] === 1'b0 && sdi_w[i] !== p_sdi[i]) viol[i] <= viol[i] + 1;
      if (cs_w[i] === 1'b1 && p_cs[i] === 1'b1 && sclk_w[i] !== p_sclk[i]) viol[i] <= viol[i] + 1;
    end
  end

`ifdef DAC_DRIVER_LDAC_EN
  logic p_ldac;
  int   ldac_start = 0;
  int   ldac_len = 0;
  always @(negedge clk) begin
    p_ldac <= ldac0;
    if (p_ldac === 1'b1 && ldac0 === 1'b0) begin
      ldac_start <= cyc;
      ldac_len   <= 1;
    end else if (ldac0 === 1'b0) begin
      ldac_len <= ldac_len + 1;
    end
  end
`endif

  task automatic send(input int i, input logic [15:0] w, output int t0);
    int k;
    @(negedge clk);
    if (i == 0) begin din0 = w; dv0 = 1'b1; end
    else begin din1 = w; dv1 = 1'b1; end
    k = 0;
    while (rdy[i] !== 1'b1 && k < 200) begin @(negedge clk); k++; end
    tests++;
    if (k >= 200) begin fails++; $display("FAIL send_ready[%0d]: din_ready got 0 required 1", i); end
    t0 = cyc;
    @(negedge clk);
    if (i == 0) dv0 = 1'b0; else dv1 = 1'b0;
  endtask

  task automatic wait_frame(input int i, input int nf);
    int k;
    k = 0;
    while (frames[i] < nf && k < 300) begin @(negedge clk); k++; end
    @(negedge clk);
    tests++;
    if (k >= 300) begin fails++; $display("FAIL frame_done[%0d]: frames got %0d required %0d", i, frames[i], nf); end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    tests++;
    if ({cs0, sclk0, sdi0, busy0, rdy0} !== 5'b11000) begin
      fails++; $display("FAIL reset_dut0: {CS,SCLK,SDI,busy,rdy} got %b required 11000", {cs0, sclk0, sdi0, busy0, rdy0});
    end
    tests++;
    if ({cs1, sclk1, sdi1, busy1, rdy1} !== 5'b11000) begin
      fails++; $display("FAIL reset_dut1: {CS,SCLK,SDI,busy,rdy} got %b required 11000", {cs1, sclk1, sdi1, busy1, rdy1});
    end
`ifdef DAC_DRIVER_LDAC_EN
    tests++;
    if ({ldac0, ldac1} !== 2'b11) begin fails++; $display("FAIL reset_ldac: got %b required 11", {ldac0, ldac1}); end
`endif
    rst = 1'b0;
    @(negedge clk);
    tests++;
    if (rdy !== 2'b11) begin fails++; $display("FAIL reset_ready: got %b required 11", rdy); end
  endtask

  task automatic test_single();
    int t0, nf;
    nf = frames[0];
    send(0, 16'hA5C3, t0);
    wait_frame(0, nf + 1);
    tests++;
    if (cs_fall_c[0] !== t0 + 1) begin fails++; $display("FAIL single_cs_fall: got %0d required %0d", cs_fall_c[0], t0 + 1); end
    tests++;
    if (first_fall_c[0] !== t0 + 3) begin fails++; $display("FAIL single_first_fall: got %0d required %0d", first_fall_c[0], t0 + 3); end
    tests++;
    if (cs_rise_c[0] !== t0 + 65) begin fails++; $display("FAIL single_cs_rise: got %0d required %0d", cs_rise_c[0], t0 + 65); end
    tests++;
    if (word[0] !== 16'hA5C3) begin fails++; $display("FAIL single_word: got %h required a5c3", word[0]); end
    tests++;
    if (falls[0] !== 16) begin fails++; $display("FAIL single_falls: got %0d required 16", falls[0]); end
    repeat (6) @(negedge clk);
`ifdef DAC_DRIVER_LDAC_EN
    tests++;
    if (ldac_start !== cs_rise_c[0] + 1) begin fails++; $display("FAIL ldac_start: got %0d required %0d", ldac_start, cs_rise_c[0] + 1); end
    tests++;
    if (ldac_len !== 2) begin fails++; $display("FAIL ldac_len: got %0d required 2", ldac_len); end
`endif
  endtask

  task automatic test_back_to_back();
    int nf, k;
    nf = frames[0];
    @(negedge clk);
    din0 = 16'h0000;
    dv0  = 1'b1;
    k = 0;
    while (rdy0 !== 1'b1 && k < 200) begin @(negedge clk); k++; end
    @(negedge clk);
    din0 = 16'hFFFF;
    wait_frame(0, nf + 1);
    tests++;
    if (word[0] !== 16'h0000) begin fails++; $display("FAIL b2b_word0: got %h required 0000", word[0]); end
    wait_frame(0, nf + 2);
    dv0 = 1'b0;
    tests++;
    if (gap_meas[0] !== 5) begin fails++; $display("FAIL b2b_gap: got %0d required 5", gap_meas[0]); end
    tests++;
    if (word[0] !== 16'hFFFF) begin fails++; $display("FAIL b2b_word1: got %h required ffff", word[0]); end
    repeat (8) @(negedge clk);
  endtask

  task automatic test_ignore();
    int t0, bad;
    bad = 0;
    send(0, 16'h1234, t0);
    for (int k = 0; k < 68; k++) begin
      if (rdy0 !== 1'b0 || busy0 !== 1'b1) bad++;
      dv0  = (cyc < t0 + 66) ? 1'($urandom_range(0, 1)) : 1'b0;
      din0 = 16'($urandom);
      @(negedge clk);
    end
    tests++;
    if (bad !== 0) begin fails++; $display("FAIL ignore_ready_busy: bad cycles got %0d required 0", bad); end
    tests++;
    if ({rdy0, busy0} !== 2'b10) begin fails++; $display("FAIL ignore_gap_end: {rdy,busy} got %b required 10 at cycle %0d", {rdy0, busy0}, cyc - t0); end
    tests++;
    if (word[0] !== 16'h1234) begin fails++; $display("FAIL ignore_word: got %h required 1234", word[0]); end
  endtask

  task automatic test_abort();
    int t0, nf, k;
    send(0, 16'h0F0F, t0);
    k = 0;
    while (cyc < t0 + 31 && k < 200) begin @(negedge clk); k++; end
    tests++;
    if (falls[0] !== 7 || sclk0 !== 1'b0) begin
      fails++; $display("FAIL abort_at_8th_fall: prior falls %0d SCLK %b required 7 and 0", falls[0], sclk0);
    end
    rst = 1'b1;
    @(negedge clk);
    tests++;
    if ({cs0, sclk0} !== 2'b11) begin fails++; $display("FAIL abort_cs_sclk: got %b required 11", {cs0, sclk0}); end
    rst = 1'b0;
    repeat (20) @(negedge clk);
    tests++;
    if (falls[0] !== 8) begin fails++; $display("FAIL abort_no_more_falls: got %0d required 8", falls[0]); end
    nf = frames[0];
    send(0, 16'h3C5A, t0);
    wait_frame(0, nf + 1);
    tests++;
    if (word[0] !== 16'h3C5A || falls[0] !== 16) begin
      fails++; $display("FAIL abort_next_frame: word %h falls %0d required 3c5a and 16", word[0], falls[0]);
    end
    repeat (6) @(negedge clk);
  endtask

  task automatic test_clkdiv1();
    int t0, nf;
    nf = frames[1];
    send(1, 16'h8001, t0);
    wait_frame(1, nf + 1);
    tests++;
    if (first_fall_c[1] !== t0 + 2) begin fails++; $display("FAIL div1_first_fall: got %0d required %0d", first_fall_c[1], t0 + 2); end
    tests++;
    if (last_fall_c[1] !== t0 + 32) begin fails++; $display("FAIL div1_last_fall: got %0d required %0d", last_fall_c[1], t0 + 32); end
    tests++;
    if (cs_rise_c[1] !== t0 + 33) begin fails++; $display("FAIL div1_cs_rise: got %0d required %0d", cs_rise_c[1], t0 + 33); end
    tests++;
    if (word[1] !== 16'h8001 || falls[1] !== 16) begin
      fails++; $display("FAIL div1_word: word %h falls %0d required 8001 and 16", word[1], falls[1]);
    end
  endtask

  task automatic test_protocol();
    tests++;
    if (viol[0] !== 0) begin fails++; $display("FAIL protocol_dut0: violations got %0d required 0", viol[0]); end
    tests++;
    if (viol[1] !== 0) begin fails++; $display("FAIL protocol_dut1: violations got %0d required 0", viol[1]); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_ignore();
    test_abort();
    test_clkdiv1();
    test_protocol();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
